ex_mem_pipe: RTL and testbench

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

---
 rtl/ex_mem_pipe.sv | 133 +++++++++++++
 tb/tb_ex_mem_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register built as a two-entry skid buffer (head + skid).
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high in the cycle before it. in_ready depends only on registered
// state, so it has no combinational path from out_ready. The head entry
// drives the MEM-side outputs. A taken branch (pc_src) and the forwarding
// bus are decoded from the head entry.
module ex_mem_pipe #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int WB_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [WB_W-1:0]  ctlwb_in,
    input  logic [2:0]       ctlm_in,
    input  logic [XLEN-1:0]  adder_in,
    input  logic             aluzero_in,
    input  logic [XLEN-1:0]  aluout_in,
    input  logic [XLEN-1:0]  readdat2_in,
    input  logic [RA_W-1:0]  rd_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WB_W-1:0]  wb_ctlout,
    output logic             branch,
    output logic             memread,
    output logic             memwrite,
    output logic [XLEN-1:0]  add_result,
    output logic             zero,
    output logic [XLEN-1:0]  alu_result,
    output logic [XLEN-1:0]  rdata2out,
    output logic [RA_W-1:0]  rd_out,
    output logic             pc_src,
    output logic             fwd_valid,
    output logic [RA_W-1:0]  fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic            branch;
        logic            memread;
        logic            memwrite;
        logic [XLEN-1:0] add;
        logic            zero;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rdata2;
        logic [RA_W-1:0] rd;
    } entry_t;

    entry_t in_entry;
    entry_t head;
    entry_t skid;
    logic   head_valid;
    logic   skid_valid;
    logic   accept;
    logic   drain;

    // Pack the incoming EX result; ctlm_in is {branch, memread, memwrite}.
    always_comb begin
        in_entry          = '0;
        in_entry.wb       = ctlwb_in;
        in_entry.branch   = ctlm_in[2];
        in_entry.memread  = ctlm_in[1];
        in_entry.memwrite = ctlm_in[0];
        in_entry.add      = adder_in;
        in_entry.zero     = aluzero_in;
        in_entry.alu      = aluout_in;
        in_entry.rdata2   = readdat2_in;
        in_entry.rd       = rd_in;
    end

    assign in_ready  = ~skid_valid;
    assign out_valid = head_valid;
    assign accept    = in_valid & in_ready;
    assign drain     = head_valid & out_ready;

    // Entry movement; accept can never coincide with a full skid because
    // in_ready is low then. Flush keeps payloads, only valids drop.
    always_ff @(posedge clock) begin
        if (reset) begin
            head       <= '0;
            skid       <= '0;
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (drain && skid_valid) begin
            head       <= skid;
            skid_valid <= 1'b0;
        end else if (accept && (!head_valid || drain)) begin
            head       <= in_entry;
            head_valid <= 1'b1;
        end else if (accept) begin
            skid       <= in_entry;
            skid_valid <= 1'b1;
        end else if (drain) begin
            head_valid <= 1'b0;
        end
    end

    // Saturating count of cycles where MEM holds off a valid head.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (head_valid && !out_ready && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    // Control is masked by head_valid; data fields keep their last value.
    always_comb begin
        wb_ctlout  = head_valid ? head.wb : '0;
        branch     = head_valid & head.branch;
        memread    = head_valid & head.memread;
        memwrite   = head_valid & head.memwrite;
        add_result = head.add;
        zero       = head.zero;
        alu_result = head.alu;
        rdata2out  = head.rdata2;
        rd_out     = head.rd;
        pc_src     = head_valid & head.branch & head.zero;
        fwd_valid  = head_valid & head.wb[0] & ~head.memread;
        fwd_rd     = head.rd;
        fwd_data   = head.alu;
    end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: per-transaction field table, streaming,
// back-pressure, flush, mid-stream reset and stall counter saturation.
// An alu_result scoreboard follows every accept and drain.
module tb_ex_mem_pipe;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int WB_W  = 2;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WB_W-1:0]  ctlwb_in;
    logic [2:0]       ctlm_in;
    logic [XLEN-1:0]  adder_in;
    logic             aluzero_in;
    logic [XLEN-1:0]  aluout_in;
    logic [XLEN-1:0]  readdat2_in;
    logic [RA_W-1:0]  rd_in;
    logic             out_valid;
    logic             out_ready;
    logic [WB_W-1:0]  wb_ctlout;
    logic             branch;
    logic             memread;
    logic             memwrite;
    logic [XLEN-1:0]  add_result;
    logic             zero;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  rdata2out;
    logic [RA_W-1:0]  rd_out;
    logic             pc_src;
    logic             fwd_valid;
    logic [RA_W-1:0]  fwd_rd;
    logic [XLEN-1:0]  fwd_data;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];

    ex_mem_pipe #(.XLEN(XLEN), .RA_W(RA_W), .WB_W(WB_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in),
        .adder_in(adder_in), .aluzero_in(aluzero_in), .aluout_in(aluout_in),
        .readdat2_in(readdat2_in), .rd_in(rd_in), .out_valid(out_valid),
        .out_ready(out_ready), .wb_ctlout(wb_ctlout), .branch(branch),
        .memread(memread), .memwrite(memwrite), .add_result(add_result),
        .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
        .rd_out(rd_out), .pc_src(pc_src), .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data), .stall_count(stall_count)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: sampled mid-cycle, describes what the next edge will do.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_drain: got 0x%0h with no entry expected", alu_result);
                end else begin
                    logic [XLEN-1:0] e;
                    e = exp_q.pop_front();
                    if (alu_result !== e) begin
                        errors++;
                        $display("FAIL sb_order: got 0x%0h expected 0x%0h", alu_result, e);
                    end
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(aluout_in);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic z,
                         input logic [31:0] alu, input logic [31:0] add,
                         input logic [31:0] rd2, input logic [4:0] rd);
        in_valid    = 1'b1;
        ctlwb_in    = wb;
        ctlm_in     = m;
        aluzero_in  = z;
        aluout_in   = alu;
        adder_in    = add;
        readdat2_in = rd2;
        rd_in       = rd;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic        z;
        logic [31:0] alu;
        logic [31:0] add;
        logic [31:0] rd2;
        logic [4:0]  rd;
        logic        e_pc;
        logic        e_fwd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{wb: 2'b01, m: 3'b100, z: 1'b1, alu: 32'h0000ABCD, add: 32'h00000100, rd2: 32'h11111111, rd: 5'd5,  e_pc: 1'b1, e_fwd: 1'b1};
        vecs[1] = '{wb: 2'b01, m: 3'b100, z: 1'b0, alu: 32'h00001234, add: 32'h00000200, rd2: 32'h22222222, rd: 5'd7,  e_pc: 1'b0, e_fwd: 1'b1};
        vecs[2] = '{wb: 2'b01, m: 3'b010, z: 1'b0, alu: 32'h0000ABCD, add: 32'h00000300, rd2: 32'h33333333, rd: 5'd5,  e_pc: 1'b0, e_fwd: 1'b0};
        vecs[3] = '{wb: 2'b00, m: 3'b001, z: 1'b1, alu: 32'hDEADBEEF, add: 32'h00000400, rd2: 32'h44444444, rd: 5'd31, e_pc: 1'b0, e_fwd: 1'b0};
        vecs[4] = '{wb: 2'b11, m: 3'b000, z: 1'b1, alu: 32'h00000042, add: 32'h00000500, rd2: 32'h55555555, rd: 5'd1,  e_pc: 1'b0, e_fwd: 1'b1};
        vecs[5] = '{wb: 2'b10, m: 3'b110, z: 1'b1, alu: 32'hCAFEF00D, add: 32'h00000600, rd2: 32'h66666666, rd: 5'd9,  e_pc: 1'b1, e_fwd: 1'b0};

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        ctlwb_in = '0; ctlm_in = '0; adder_in = '0; aluzero_in = 1'b0;
        aluout_in = '0; readdat2_in = '0; rd_in = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wb", 32'(wb_ctlout), 32'd0);
        chk("rst_ctl", {29'd0, branch, memread, memwrite}, 32'd0);
        chk("rst_pc_src", 32'(pc_src), 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        chk("rst_alu", alu_result, 32'd0);

        // Streaming 1,2,3 with out_ready held high
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(2'b00, 3'b000, 1'b0, 32'(i), 32'd0, 32'd0, 5'd0);
            tick();
            chk("stream_alu", alu_result, 32'(i));
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_empty", 32'(out_valid), 32'd0);

        // Table: one transaction per vector, held then drained
        for (int i = 0; i < 6; i++) begin
            out_ready = 1'b0;
            drive(vecs[i].wb, vecs[i].m, vecs[i].z, vecs[i].alu, vecs[i].add, vecs[i].rd2, vecs[i].rd);
            tick();
            in_valid = 1'b0;
            chk("vec_pc_src", 32'(pc_src), 32'(vecs[i].e_pc));
            chk("vec_fwd_valid", 32'(fwd_valid), 32'(vecs[i].e_fwd));
            chk("vec_fwd_rd", 32'(fwd_rd), 32'(vecs[i].rd));
            chk("vec_fwd_data", fwd_data, vecs[i].alu);
            chk("vec_ctlm", {29'd0, branch, memread, memwrite}, 32'(vecs[i].m));
            chk("vec_wb", 32'(wb_ctlout), 32'(vecs[i].wb));
            chk("vec_zero", 32'(zero), 32'(vecs[i].z));
            chk("vec_add", add_result, vecs[i].add);
            chk("vec_rdata2", rdata2out, vecs[i].rd2);
            chk("vec_rd_out", 32'(rd_out), 32'(vecs[i].rd));
            out_ready = 1'b1;
            tick();
            chk("vec_drain_valid", 32'(out_valid), 32'd0);
            chk("vec_drain_pc_src", 32'(pc_src), 32'd0);
            chk("vec_drain_ctl", {27'd0, wb_ctlout, branch, memread, memwrite}, 32'd0);
            chk("vec_hold_alu", alu_result, vecs[i].alu);
        end

        // Back-pressure: A=0x10, B=0x20, hold, then release
        out_ready = 1'b0;
        do_reset();
        drive(2'b01, 3'b000, 1'b0, 32'h10, 32'd0, 32'd0, 5'd2);
        tick();
        drive(2'b01, 3'b000, 1'b0, 32'h20, 32'd0, 32'd0, 5'd3);
        tick();
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_head", alu_result, 32'h10);
        chk("bp_stall_1", 32'(stall_count), 32'd1);
        drive(2'b01, 3'b000, 1'b0, 32'h30, 32'd0, 32'd0, 5'd4);
        for (int i = 0; i < 3; i++) tick();
        chk("bp_stall_4", 32'(stall_count), 32'd4);
        chk("bp_head_kept", alu_result, 32'h10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_second", alu_result, 32'h20);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_stall_final", 32'(stall_count), 32'd4);

        // Flush with both entries full; MEM consumes head in the flush cycle
        out_ready = 1'b0;
        do_reset();
        drive(2'b01, 3'b111, 1'b1, 32'h55, 32'd0, 32'd0, 5'd6);
        tick();
        drive(2'b01, 3'b111, 1'b1, 32'h66, 32'd0, 32'd0, 5'd7);
        tick();
        chk("fl_full", 32'(in_ready), 32'd0);
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(2'b01, 3'b100, 1'b1, 32'h99, 32'd0, 32'd0, 5'd8);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_ctl", {29'd0, branch, memread, memwrite}, 32'd0);
        chk("fl_pc_src", 32'(pc_src), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_stall_kept", 32'(stall_count), 32'd1);
        tick();
        chk("fl_discard", 32'(out_valid), 32'd0);

        // Reset mid-stream
        drive(2'b01, 3'b000, 1'b0, 32'h77, 32'd0, 32'd0, 5'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_alu_cleared", alu_result, 32'd0);
        chk("mr_stall", 32'(stall_count), 32'd0);
        tick();
        chk("mr_still_empty", 32'(out_valid), 32'd0);

        // Saturation: 20 stall cycles on a 4-bit counter
        drive(2'b00, 3'b000, 1'b0, 32'($urandom_range(1, 255)), 32'd0, 32'd0, 5'd0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", 32'(stall_count), 32'd15);
        do_reset();
        chk("sat_reset", 32'(stall_count), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
